// File: rtl/pkt_fifo.sv
// pkt_fifo: synchronous packet FIFO carrying {src, dst, data} entries.
// Occupancy is tracked in a dedicated count register. All status flags decode
// from that register, so they never depend on the current request inputs.
// SHOW_AHEAD selects a registered read port (0) or first-word fall-through (1).
module pkt_fifo #(
  parameter int SRC_W      = 8,
  parameter int DST_W      = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  parameter int SHOW_AHEAD = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [SRC_W-1:0]         src_in,
  input  logic [DST_W-1:0]         dst_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     writep,
  input  logic                     readp,
  input  logic                     clr_errp,
  output logic [SRC_W-1:0]         src_out,
  output logic [DST_W-1:0]         dst_out,
  output logic [DATA_W-1:0]        data_out,
  output logic                     emptyp,
  output logic                     fullp,
  output logic                     almost_emptyp,
  output logic                     almost_fullp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflowp,
  output logic                     underflowp
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = SRC_W + DST_W + DATA_W;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  // Storage is deliberately left out of reset; valid entries are defined by the pointers.
  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;
  logic [EW-1:0] head;

  // Status flags decode from the registered occupancy only.
  assign emptyp        = (count_q == '0);
  assign fullp         = (count_q == DEPTH_C);
  assign almost_emptyp = (count_q <= AEMPTY_C);
  assign almost_fullp  = (count_q >= AFULL_C);
  assign count         = count_q;
  assign overflowp     = ovf_q;
  assign underflowp    = unf_q;
  assign head          = mem_q[rd_ptr_q];

  // Acceptance, pointer/count next state and sticky error next state.
  always_comb begin
    wr_acc   = writep && !fullp;
    rd_acc   = readp && !emptyp;
    wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
    // A rejection in the same cycle as a clear keeps the flag set.
    ovf_d = (writep && fullp)  ? 1'b1 : (clr_errp ? 1'b0 : ovf_q);
    unf_d = (readp  && emptyp) ? 1'b1 : (clr_errp ? 1'b0 : unf_q);
  end

  // Control state: pointers, occupancy and error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Entry storage write on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= {src_in, dst_in, data_in};
    end
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_fwft
      // Head entry is presented directly; outputs read as zero while empty.
      assign {src_out, dst_out, data_out} = emptyp ? '0 : head;
    end else begin : g_reg
      logic [EW-1:0] out_q, out_d;

      // Output register loads the head on an accepted read and otherwise holds.
      always_comb begin
        out_d = rd_acc ? head : out_q;
      end

      // Registered read port, cleared by reset.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign {src_out, dst_out, data_out} = out_q;
    end
  endgenerate

endmodule

// File: tb/tb_pkt_fifo.sv
// tb_pkt_fifo: drives a registered-read and a fall-through instance with identical
// stimulus and compares both against a queue-based reference model.
module tb_pkt_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 14;
  localparam int AEMPTY = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  src_in = '0;
  logic [7:0]  dst_in = '0;
  logic [31:0] data_in = '0;
  logic        writep = 1'b0;
  logic        readp = 1'b0;
  logic        clr_errp = 1'b0;

  logic [7:0]  r_src, r_dst, f_src, f_dst;
  logic [31:0] r_data, f_data;
  logic        r_emptyp, r_fullp, r_aemp, r_afull, r_ovf, r_unf;
  logic        f_emptyp, f_fullp, f_aemp, f_afull, f_ovf, f_unf;
  logic [4:0]  r_count, f_count;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [47:0] mq[$];
  logic [47:0] m_out0;
  logic        m_ovf, m_unf;

  always #5 clk = ~clk;

  pkt_fifo #(.DEPTH(DEPTH), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .SHOW_AHEAD(0)) u_reg (
    .clk(clk), .rstn(rstn), .src_in(src_in), .dst_in(dst_in), .data_in(data_in),
    .writep(writep), .readp(readp), .clr_errp(clr_errp),
    .src_out(r_src), .dst_out(r_dst), .data_out(r_data),
    .emptyp(r_emptyp), .fullp(r_fullp), .almost_emptyp(r_aemp), .almost_fullp(r_afull),
    .count(r_count), .overflowp(r_ovf), .underflowp(r_unf)
  );

  pkt_fifo #(.DEPTH(DEPTH), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .SHOW_AHEAD(1)) u_fwft (
    .clk(clk), .rstn(rstn), .src_in(src_in), .dst_in(dst_in), .data_in(data_in),
    .writep(writep), .readp(readp), .clr_errp(clr_errp),
    .src_out(f_src), .dst_out(f_dst), .data_out(f_data),
    .emptyp(f_emptyp), .fullp(f_fullp), .almost_emptyp(f_aemp), .almost_fullp(f_afull),
    .count(f_count), .overflowp(f_ovf), .underflowp(f_unf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [47:0] rnd_entry();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    return {a[15:0], b};
  endfunction

  function automatic logic [47:0] fill_entry(input int i);
    logic [7:0] i8;
    i8 = 8'(i);
    return {i8, 8'hFF - i8, 32'(i)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out0 = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic check_all();
    int sz;
    logic [47:0] exp_f;
    sz = mq.size();
    exp_f = (sz == 0) ? 48'h0 : mq[0];
    check("count", 64'(r_count), 64'(sz));
    check("emptyp", 64'(r_emptyp), 64'(sz == 0));
    check("fullp", 64'(r_fullp), 64'(sz == DEPTH));
    check("almost_emptyp", 64'(r_aemp), 64'(sz <= AEMPTY));
    check("almost_fullp", 64'(r_afull), 64'(sz >= AFULL));
    check("overflowp", 64'(r_ovf), 64'(m_ovf));
    check("underflowp", 64'(r_unf), 64'(m_unf));
    check("reg_out", 64'({r_src, r_dst, r_data}), 64'(m_out0));
    check("fwft_out", 64'({f_src, f_dst, f_data}), 64'(exp_f));
    check("fwft_count", 64'(f_count), 64'(sz));
    check("fwft_flags", 64'({f_emptyp, f_fullp, f_aemp, f_afull, f_ovf, f_unf}),
          64'({sz == 0, sz == DEPTH, sz <= AEMPTY, sz >= AFULL, m_ovf, m_unf}));
  endtask

  // One clock: apply requests, advance the model at the edge, then compare.
  task automatic step(input logic w, input logic r, input logic c, input logic [47:0] e);
    bit full, empty;
    writep = w;
    readp  = r;
    clr_errp = c;
    {src_in, dst_in, data_in} = e;
    @(posedge clk);
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (r && !empty) begin
      m_out0 = mq.pop_front();
    end
    if (w && !full) mq.push_back(e);
    if (w && full) m_ovf = 1'b1;
    else if (c)    m_ovf = 1'b0;
    if (r && empty) m_unf = 1'b1;
    else if (c)     m_unf = 1'b0;
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 48'h0);
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge.
  task automatic async_reset();
    writep = 1'b0;
    readp = 1'b0;
    clr_errp = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check("rst_count", 64'(r_count), 64'd0);
    check("rst_flags", 64'({r_emptyp, r_aemp, r_fullp, r_afull, r_ovf, r_unf}), 64'b110000);
    check("rst_data", 64'(r_data), 64'd0);
    check_all();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rstn = 1'b1;

    // Partial fill then reset during traffic
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, rnd_entry());
    check("pre_reset_count", 64'(r_count), 64'd7);
    async_reset();

    // Fill with known pattern; first write lands at entry 0 after reset
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, fill_entry(i));
      check("fill_count", 64'(r_count), 64'(i + 1));
      check("fill_afull", 64'(r_afull), 64'(i + 1 >= 14));
    end
    check("full_flag", 64'(r_fullp), 64'd1);
    step(1'b1, 1'b0, 1'b0, rnd_entry());
    check("ovf_17th", 64'({r_ovf, r_count}), 64'({1'b1, 5'd16}));

    // Drain in order, then an extra read
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 48'h0);
      check("drain_data", 64'(r_data), 64'(i));
      check("drain_dst", 64'(r_dst), 64'(8'hFF - 8'(i)));
    end
    check("drain_empty", 64'(r_emptyp), 64'd1);
    step(1'b0, 1'b1, 1'b0, 48'h0);
    check("unf_extra_read", 64'(r_unf), 64'd1);
    check("hold_data", 64'(r_data), 64'd15);

    // Error clear with both set
    step(1'b0, 1'b0, 1'b1, 48'h0);
    check("clr_both", 64'({r_ovf, r_unf}), 64'b00);

    // Fill, then clear collides with a rejected write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, rnd_entry());
    step(1'b1, 1'b0, 1'b1, rnd_entry());
    check("set_beats_clr", 64'(r_ovf), 64'd1);
    step(1'b0, 1'b0, 1'b1, 48'h0);

    // Simultaneous at full
    step(1'b1, 1'b1, 1'b0, rnd_entry());
    check("full_wr_rd", 64'({r_count, r_ovf}), 64'({5'd15, 1'b1}));

    // Drain, clear, simultaneous at empty
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 48'h0);
    step(1'b0, 1'b0, 1'b1, 48'h0);
    step(1'b1, 1'b1, 1'b0, rnd_entry());
    check("empty_wr_rd", 64'({r_count, r_unf}), 64'({5'd1, 1'b1}));
    step(1'b0, 1'b1, 1'b1, 48'h0);

    // Fall-through visibility
    step(1'b1, 1'b0, 1'b0, {8'h11, 8'h22, 32'hA5A5A5A5});
    check("fwft_visible", 64'({f_emptyp, f_data}), 64'({1'b0, 32'hA5A5A5A5}));
    idle();
    check("fwft_hold", 64'(f_data), 64'h00000000A5A5A5A5);
    step(1'b0, 1'b1, 1'b0, 48'h0);
    check("fwft_empty", 64'({f_emptyp, f_data}), 64'({1'b1, 32'h0}));

    // Steady state at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, rnd_entry());
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b1, 1'b0, rnd_entry());
      check("steady_count", 64'(r_count), 64'd5);
    end

    // Random traffic with varying bias and occasional reset
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = (i / 100) % 2 == 0 ? 70 : 30;
      rp = 100 - wp;
      if ($urandom_range(0, 249) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
             ($urandom_range(0, 19) == 0), rnd_entry());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
